// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM states, register map, STAT layout.
package irq_ctrl_pkg;

  localparam int unsigned BITS_DEF    = 32;
  localparam int unsigned N_IRQ_DEF   = 4;
  localparam int unsigned ID_BITS_DEF = 2;
  localparam logic [31:0] BASE_DEF    = 32'hFFFF0F00;

  // Register offsets from BASE
  localparam int unsigned MASK_OFS = 0;
  localparam int unsigned PEND_OFS = 4;
  localparam int unsigned STAT_OFS = 8;
  localparam int unsigned EOI_OFS  = 12;

  // STAT register field positions
  localparam int unsigned STAT_GIE_BIT   = 0;
  localparam int unsigned STAT_STATE_LSB = 1;
  localparam int unsigned STAT_STATE_W   = 2;
  localparam int unsigned STAT_ID_LSB    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: reports whether any bit is set and the lowest set index.
module irq_priority_encoder #(
  parameter int unsigned N_IRQ   = 4,
  parameter int unsigned ID_BITS = 2
) (
  input  logic [N_IRQ-1:0]   vec_i,
  output logic               valid_o,
  output logic [ID_BITS-1:0] idx_o
);

  // Scan from the top so the lowest set index is the last one written
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        valid_o = 1'b1;
        idx_o   = ID_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: masks and prioritises device IRQ lines,
// requests the CPU via INTR/INTID, and blocks further requests until EOI.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned     BITS    = BITS_DEF,
  parameter int unsigned     N_IRQ   = N_IRQ_DEF,
  parameter int unsigned     ID_BITS = ID_BITS_DEF,
  parameter logic [BITS-1:0] BASE    = BITS'(BASE_DEF)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [BITS-1:0]    ADDRBUS,
  inout  wire  [BITS-1:0]    DATABUS,
  input  logic               WE,
  input  logic [N_IRQ-1:0]   IRQ_IN,
  input  logic               INTA,
  output logic               INTR,
  output logic [ID_BITS-1:0] INTID
);

  localparam logic [BITS-1:0] ADDR_MASK = BASE + BITS'(MASK_OFS);
  localparam logic [BITS-1:0] ADDR_PEND = BASE + BITS'(PEND_OFS);
  localparam logic [BITS-1:0] ADDR_STAT = BASE + BITS'(STAT_OFS);
  localparam logic [BITS-1:0] ADDR_EOI  = BASE + BITS'(EOI_OFS);

  irq_state_e         state_q, state_d;
  logic [N_IRQ-1:0]   irq_q, irq_d;
  logic [N_IRQ-1:0]   mask_q, mask_d;
  logic               gie_q, gie_d;
  logic               intr_q, intr_d;
  logic [ID_BITS-1:0] intid_q, intid_d;

  logic [N_IRQ-1:0]   pending_c;
  logic               enc_valid_c;
  logic [ID_BITS-1:0] enc_idx_c;
  logic               sel_mask_c, sel_pend_c, sel_stat_c, sel_eoi_c;
  logic               wr_mask_c, wr_stat_c, wr_eoi_c;
  logic               rd_en_c;
  logic [BITS-1:0]    rdata_c;
  logic               unused_wdata_c;

  assign sel_mask_c = (ADDRBUS == ADDR_MASK);
  assign sel_pend_c = (ADDRBUS == ADDR_PEND);
  assign sel_stat_c = (ADDRBUS == ADDR_STAT);
  assign sel_eoi_c  = (ADDRBUS == ADDR_EOI);
  assign wr_mask_c  = WE && sel_mask_c;
  assign wr_stat_c  = WE && sel_stat_c;
  assign wr_eoi_c   = WE && sel_eoi_c;

  // Only the low data bits carry register content on writes
  assign unused_wdata_c = ^DATABUS[BITS-1:N_IRQ];

  // Pending is computed from the registered mask, so mask writes land one cycle later
  assign pending_c = irq_q & mask_q;

  irq_priority_encoder #(
    .N_IRQ   (N_IRQ),
    .ID_BITS (ID_BITS)
  ) u_prio (
    .vec_i   (pending_c),
    .valid_o (enc_valid_c),
    .idx_o   (enc_idx_c)
  );

  // All controller flops; async reset drops INTR immediately
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      irq_q   <= '0;
      mask_q  <= '0;
      gie_q   <= 1'b0;
      intr_q  <= 1'b0;
      intid_q <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      mask_q  <= mask_d;
      gie_q   <= gie_d;
      intr_q  <= intr_d;
      intid_q <= intid_d;
    end
  end

  // Input sampling and software-visible register updates
  always_comb begin
    irq_d  = IRQ_IN;
    mask_d = mask_q;
    gie_d  = gie_q;
    if (wr_mask_c) mask_d = DATABUS[N_IRQ-1:0];
    if (wr_stat_c) gie_d = DATABUS[STAT_GIE_BIT];
  end

  // Next-state: INTA beats withdrawal; SERVICE ignores everything but EOI
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gie_q && enc_valid_c) state_d = REQUEST;
      end
      REQUEST: begin
        if (INTA) state_d = SERVICE;
        else if (!pending_c[intid_q] || !gie_q) state_d = IDLE;
      end
      SERVICE: begin
        if (wr_eoi_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs: INTR high only while the request is live, INTID latched on entry
  always_comb begin
    intr_d  = 1'b0;
    intid_d = intid_q;
    case (state_q)
      IDLE: begin
        if (gie_q && enc_valid_c) begin
          intr_d  = 1'b1;
          intid_d = enc_idx_c;
        end
      end
      REQUEST: begin
        intr_d = !INTA && pending_c[intid_q] && gie_q;
      end
      default: intr_d = 1'b0;
    endcase
  end

  // Combinational read mux; EOI is owned but reads as zero
  always_comb begin
    rd_en_c = 1'b0;
    rdata_c = '0;
    if (!WE) begin
      if (sel_mask_c) begin
        rd_en_c              = 1'b1;
        rdata_c[N_IRQ-1:0]   = mask_q;
      end else if (sel_pend_c) begin
        rd_en_c              = 1'b1;
        rdata_c[N_IRQ-1:0]   = pending_c;
      end else if (sel_stat_c) begin
        rd_en_c                                  = 1'b1;
        rdata_c[STAT_GIE_BIT]                    = gie_q;
        rdata_c[STAT_STATE_LSB +: STAT_STATE_W]  = state_q;
        rdata_c[STAT_ID_LSB +: ID_BITS]          = intid_q;
      end else if (sel_eoi_c) begin
        rd_en_c = 1'b1;
      end
    end
  end

  assign DATABUS = rd_en_c ? rdata_c : {BITS{1'bz}};
  assign INTR    = intr_q;
  assign INTID   = intid_q;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: expectations queued at stimulus, checked after the edge.
module tb_irq_controller;

  localparam logic [31:0] A_MASK  = 32'hFFFF0F00;
  localparam logic [31:0] A_PEND  = 32'hFFFF0F04;
  localparam logic [31:0] A_STAT  = 32'hFFFF0F08;
  localparam logic [31:0] A_EOI   = 32'hFFFF0F0C;
  localparam logic [31:0] A_OTHER = 32'h00001000;

  logic        CLK;
  logic        RESET;
  logic [31:0] ADDRBUS;
  wire  [31:0] DATABUS;
  logic        WE;
  logic [3:0]  IRQ_IN;
  logic        INTA;
  logic        INTR;
  logic [1:0]  INTID;

  logic        tb_drv;
  logic [31:0] tb_wdata;

  assign DATABUS = tb_drv ? tb_wdata : 32'bz;

  irq_controller dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .ADDRBUS (ADDRBUS),
    .DATABUS (DATABUS),
    .WE      (WE),
    .IRQ_IN  (IRQ_IN),
    .INTA    (INTA),
    .INTR    (INTR),
    .INTID   (INTID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    int          sel;   // 0 INTR, 1 INTID, 2 DATABUS, 3 DATABUS[2:0]
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] got;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        0:       got = {31'd0, INTR};
        1:       got = {30'd0, INTID};
        2:       got = DATABUS;
        default: got = DATABUS & 32'h7;
      endcase
      chk(e.tag, got, e.val);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One clock with INTR and INTID expected after the edge
  task automatic cyc(input string tag, input bit intr, input logic [1:0] id);
    push_exp({tag, ".intr"}, 0, {31'd0, intr});
    push_exp({tag, ".id"}, 1, {30'd0, id});
    tick();
    drain();
  endtask

  // One clock with only INTR expected after the edge
  task automatic cycn(input string tag, input bit intr);
    push_exp({tag, ".intr"}, 0, {31'd0, intr});
    tick();
    drain();
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input string tag, input bit intr);
    ADDRBUS  = addr;
    tb_wdata = data;
    tb_drv   = 1'b1;
    WE       = 1'b1;
    push_exp({tag, ".intr"}, 0, {31'd0, intr});
    tick();
    drain();
    WE      = 1'b0;
    tb_drv  = 1'b0;
    ADDRBUS = A_OTHER;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] addr, input int sel,
                          input logic [31:0] exp);
    ADDRBUS = addr;
    WE      = 1'b0;
    push_exp(tag, sel, exp);
    #1;
    drain();
    ADDRBUS = A_OTHER;
  endtask

  initial begin
    RESET    = 1'b1;
    WE       = 1'b0;
    INTA     = 1'b0;
    ADDRBUS  = A_OTHER;
    tb_drv   = 1'b0;
    tb_wdata = 32'd0;
    IRQ_IN   = 4'hF;

    // Reset state with all lines high and mask clear
    repeat (2) @(posedge CLK);
    #1;
    push_exp("rst.intr", 0, 32'd0);
    push_exp("rst.id", 1, 32'd0);
    drain();
    RESET = 1'b0;
    cyc("a.idle0", 1'b0, 2'd0);
    cyc("a.idle1", 1'b0, 2'd0);
    bus_read("a.stat", A_STAT, 2, 32'h0);
    bus_read("a.pend", A_PEND, 2, 32'h0);
    bus_read("a.mask", A_MASK, 2, 32'h0);
    // Unrelated address: the bench's own weak pattern must come back untouched
    tb_drv   = 1'b1;
    tb_wdata = 32'h5A5AA5A5;
    bus_read("a.other", A_OTHER, 2, 32'h5A5AA5A5);
    tb_drv   = 1'b0;

    // Basic request / acknowledge / EOI
    IRQ_IN = 4'h0;
    bus_write(A_MASK, 32'hFFFF_FFFF, "b.wmask", 1'b0);
    bus_write(A_STAT, 32'h1, "b.wgie", 1'b0);
    bus_read("b.mask", A_MASK, 2, 32'hF);
    IRQ_IN = 4'b0110;
    cyc("b.k", 1'b0, 2'd0);
    cyc("b.k1", 1'b1, 2'd1);
    bus_read("b.stat_req", A_STAT, 2, 32'h13);
    bus_read("b.pend", A_PEND, 2, 32'h6);
    INTA = 1'b1;
    cyc("b.inta", 1'b0, 2'd1);
    INTA = 1'b0;
    bus_read("b.stat_svc", A_STAT, 2, 32'h15);
    cyc("b.svc", 1'b0, 2'd1);
    bus_write(A_EOI, 32'hDEAD_BEEF, "b.eoi", 1'b0);
    bus_read("b.stat_idle", A_STAT, 2, 32'h11);
    cyc("b.rereq", 1'b1, 2'd1);
    bus_read("b.eoi_rd", A_EOI, 2, 32'h0);

    // Move to ID 2, then no nesting while in service
    IRQ_IN = 4'b0100;
    cyc("c.old", 1'b1, 2'd1);
    cycn("c.wd", 1'b0);
    cyc("c.req2", 1'b1, 2'd2);
    INTA = 1'b1;
    cyc("c.inta", 1'b0, 2'd2);
    INTA = 1'b0;
    IRQ_IN = 4'b0101;
    cyc("c.nest0", 1'b0, 2'd2);
    INTA = 1'b1;
    cyc("c.nest1", 1'b0, 2'd2);
    INTA = 1'b0;
    cyc("c.nest2", 1'b0, 2'd2);
    bus_write(A_EOI, 32'h0, "c.eoi", 1'b0);
    cyc("c.req0", 1'b1, 2'd0);
    IRQ_IN = 4'b0000;
    INTA   = 1'b1;
    cyc("c.inta0", 1'b0, 2'd0);
    INTA   = 1'b0;
    bus_write(A_EOI, 32'h0, "c.eoi2", 1'b0);
    cyc("c.quiet", 1'b0, 2'd0);

    // ID 3 withdrawn without INTA
    IRQ_IN = 4'b1000;
    cyc("d.s", 1'b0, 2'd0);
    cyc("d.req3", 1'b1, 2'd3);
    IRQ_IN = 4'b0000;
    cyc("d.hold", 1'b1, 2'd3);
    cycn("d.wd", 1'b0);
    bus_read("d.st", A_STAT, 3, 32'h1);

    // ID 3 dropped but INTA wins in the same cycle
    IRQ_IN = 4'b1000;
    cycn("d2.s", 1'b0);
    cyc("d2.req3", 1'b1, 2'd3);
    IRQ_IN = 4'b0000;
    cyc("d2.hold", 1'b1, 2'd3);
    INTA = 1'b1;
    cyc("d2.inta", 1'b0, 2'd3);
    INTA = 1'b0;
    bus_read("d2.st", A_STAT, 3, 32'h5);
    bus_write(A_EOI, 32'h0, "d2.eoi", 1'b0);
    cycn("d2.quiet", 1'b0);

    // Mask clear withdraws; GIE=0 blocks everything
    IRQ_IN = 4'b0010;
    cycn("e.s", 1'b0);
    cyc("e.req1", 1'b1, 2'd1);
    bus_write(A_MASK, 32'hD, "e.wmask", 1'b1);
    cycn("e.wd", 1'b0);
    bus_read("e.pend", A_PEND, 2, 32'h0);
    bus_write(A_MASK, 32'hF, "e.wmask2", 1'b0);
    cyc("e.rereq", 1'b1, 2'd1);
    bus_write(A_STAT, 32'h0, "e.gie0", 1'b1);
    cycn("e.wd_gie", 1'b0);
    IRQ_IN = 4'hF;
    for (int i = 0; i < 3; i++) cycn("e.nogie", 1'b0);
    bus_read("e.pend_all", A_PEND, 2, 32'hF);
    bus_read("e.st", A_STAT, 3, 32'h0);

    // Reset during SERVICE
    IRQ_IN = 4'b1000;
    bus_write(A_STAT, 32'h1, "f.gie", 1'b0);
    cyc("f.req3", 1'b1, 2'd3);
    INTA = 1'b1;
    cyc("f.inta", 1'b0, 2'd3);
    INTA = 1'b0;
    RESET = 1'b1;
    push_exp("f.rst.intr", 0, 32'd0);
    push_exp("f.rst.id", 1, 32'd0);
    #1;
    drain();
    bus_read("f.rst.stat", A_STAT, 2, 32'h0);
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) cyc("f.post", 1'b0, 2'd0);
    bus_read("f.mask", A_MASK, 2, 32'h0);

    // Reset during REQUEST drops INTR at once
    bus_write(A_MASK, 32'hF, "g.wmask", 1'b0);
    bus_write(A_STAT, 32'h1, "g.gie", 1'b0);
    cyc("g.req3", 1'b1, 2'd3);
    RESET = 1'b1;
    push_exp("g.rst.intr", 0, 32'd0);
    push_exp("g.rst.id", 1, 32'd0);
    #1;
    drain();
    tick();
    RESET = 1'b0;
    cyc("g.post", 1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
